mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-serial memory bus: one byte per cycle, driven by the memory controller.
- Contains a synchronous byte RAM plus a memory-mapped IO window (mem_a[17:16]==2'b11) with a paced UART-style TX FIFO, an RX FIFO, a status register and a simulation-halt register.
- Drives mem_din with fixed 1-cycle read latency and io_buffer_full back to the controller.
- Instantiated beside the CPU core in the SoC top and in the system testbench.

---
 rtl/mem_io_responder_pkg.sv | 26 ++
 rtl/mem_io_responder_if.sv | 26 ++
 rtl/mem_io_responder_byte_fifo.sv | 53 +++++
 rtl/mem_io_responder.sv | 158 +++++++++++++++
 tb/tb_mem_io_responder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared decode constants and types for the memory-side responder.
package mem_io_pkg;

  localparam logic [1:0] IO_SEL = 2'b11;

  localparam logic [3:0] IO_UART = 4'h0;
  localparam logic [3:0] IO_STAT = 4'h4;
  localparam logic [3:0] IO_CNT  = 4'h8;

  localparam int STAT_RX_NE   = 0;
  localparam int STAT_TX_FULL = 1;
  localparam int STAT_TX_OVF  = 2;
  localparam int STAT_CNT_EN  = 3;

  // Which register feeds mem_din on the cycle after an access.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } rd_src_e;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus plus TX/RX byte streams and halt signals of the responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        sim_halt;
  logic [7:0]  halt_code;

  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
    input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, sim_halt, halt_code
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
    output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, sim_halt, halt_code
  );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO of depth 2**AW; a pop on empty is ignored, a push on full is accepted only with a pop.
module byte_fifo #(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  localparam logic [AW:0] DEPTH = (AW + 1)'(1 << AW);

  logic [7:0]    mem_q [1 << AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM plus IO window (UART FIFOs, status, halt).
// Define MEM_IO_CYCLE_CNT_EN to add the free-running cycle counter at IO offsets 0x8-0xB.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int ADDR_WID = 17,
  parameter int FIFO_AW  = 3,
  parameter int TX_GAP   = 4
) (
  input logic               clk,
  input logic               rst,
  mem_io_responder_if.slave bus
);
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int PACE_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam logic [FIFO_AW:0] TX_HIGH_WATER = (FIFO_AW + 1)'(DEPTH - 1);

  logic                io, io_rd, io_wr;
  logic [3:0]          offset;
  logic [ADDR_WID-1:0] ram_addr;

  assign io       = is_io(bus.mem_a);
  assign io_rd    = io & ~bus.mem_wr;
  assign io_wr    = io & bus.mem_wr;
  assign offset   = bus.mem_a[3:0];
  assign ram_addr = bus.mem_a[ADDR_WID-1:0];

  // Read-first RAM: the registered read sees the byte before this cycle's write.
  logic [7:0] ram_q [2**ADDR_WID];
  logic [7:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (bus.mem_wr && !io && !rst) ram_q[ram_addr] <= bus.mem_dout;
    ram_rd_q <= ram_q[ram_addr];
  end

  logic              tx_push, tx_pop, tx_full, tx_empty, tx_valid;
  logic [7:0]        tx_dout;
  logic [FIFO_AW:0]  tx_count;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]        rx_dout;
  logic [FIFO_AW:0]  rx_count;

  byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.mem_dout),
    .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(bus.rx_data),
    .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  rd_src_e     rd_src_q, rd_src_d;
  logic [7:0]  io_rd_q, io_rd_d;
  logic        halt_q, halt_d;
  logic [7:0]  halt_code_q, halt_code_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [7:0]  status;
`ifdef MEM_IO_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:8] snap_q, snap_d;
`endif

  assign tx_valid = ~tx_empty & (pace_q == '0);

  always_comb begin
    tx_push = io_wr && (offset == IO_UART);
    tx_pop  = tx_valid && bus.tx_ready;
    rx_push = bus.rx_valid && !rx_full;
    rx_pop  = io_rd && (offset == IO_UART);

    status               = '0;
    status[STAT_RX_NE]   = ~rx_empty;
    status[STAT_TX_FULL] = tx_full;
    status[STAT_TX_OVF]  = tx_ovf_q;
`ifdef MEM_IO_CYCLE_CNT_EN
    status[STAT_CNT_EN]  = 1'b1;
    cnt_d  = cnt_q + 32'd1;
    snap_d = (io_rd && offset == IO_CNT) ? cnt_q[31:8] : snap_q;
`endif

    io_rd_d = '0;
    if (io_rd) begin
      case (offset)
        IO_UART: io_rd_d = rx_empty ? 8'h00 : rx_dout;
        IO_STAT: io_rd_d = status;
`ifdef MEM_IO_CYCLE_CNT_EN
        IO_CNT:          io_rd_d = cnt_q[7:0];
        IO_CNT + 4'd1:   io_rd_d = snap_q[15:8];
        IO_CNT + 4'd2:   io_rd_d = snap_q[23:16];
        IO_CNT + 4'd3:   io_rd_d = snap_q[31:24];
`endif
        default: io_rd_d = '0;
      endcase
    end
    rd_src_d = io ? SRC_IO : SRC_RAM;

    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    if (io_wr && offset == IO_STAT && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = bus.mem_dout;
    end

    // A full FIFO still takes the byte when the sink drains a slot this cycle.
    tx_ovf_d = tx_ovf_q | (tx_push & tx_full & ~tx_pop);

    pace_d = pace_q;
    if (tx_pop) pace_d = PACE_W'(TX_GAP);
    else if (pace_q != '0) pace_d = pace_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_src_q    <= SRC_ZERO;
      io_rd_q     <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      tx_ovf_q    <= 1'b0;
      pace_q      <= '0;
`ifdef MEM_IO_CYCLE_CNT_EN
      cnt_q       <= '0;
      snap_q      <= '0;
`endif
    end else begin
      rd_src_q    <= rd_src_d;
      io_rd_q     <= io_rd_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      tx_ovf_q    <= tx_ovf_d;
      pace_q      <= pace_d;
`ifdef MEM_IO_CYCLE_CNT_EN
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
`endif
    end
  end

  always_comb begin
    case (rd_src_q)
      SRC_RAM: bus.mem_din = ram_rd_q;
      SRC_IO:  bus.mem_din = io_rd_q;
      default: bus.mem_din = 8'h00;
    endcase
  end

  assign bus.io_buffer_full = (tx_count >= TX_HIGH_WATER);
  assign bus.tx_valid       = tx_valid;
  assign bus.tx_data        = tx_dout;
  assign bus.rx_ready       = ~rx_full;
  assign bus.sim_halt       = halt_q;
  assign bus.halt_code      = halt_code_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.mem_a, rx_count};
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with scoreboard queues for reads, RX and TX bytes.
module tb_mem_io_responder;
  localparam int TX_GAP = 4;
`ifdef MEM_IO_CYCLE_CNT_EN
  localparam logic [7:0] STAT_BASE = 8'h08;
`else
  localparam logic [7:0] STAT_BASE = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_io_responder_if bus_if();

  mem_io_responder #(.ADDR_WID(17), .FIFO_AW(3), .TX_GAP(TX_GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] rd_q[$];
  logic [7:0] rx_model[$];
  logic [7:0] tx_model[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus_if.mem_a    = a;
    bus_if.mem_wr   = wr;
    bus_if.mem_dout = d;
    cyc();
    bus_if.mem_a    = '0;
    bus_if.mem_wr   = 1'b0;
    bus_if.mem_dout = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus_cyc(a, 1'b1, d);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus_cyc(a, 1'b0, 8'h00);
    check(tag, bus_if.mem_din, rd_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    rst = 1'b1;
    bus_if.mem_a = '0; bus_if.mem_wr = 1'b0; bus_if.mem_dout = '0;
    bus_if.tx_ready = 1'b0; bus_if.rx_valid = 1'b0; bus_if.rx_data = '0;
    repeat (3) cyc();
    check("rst_mem_din", bus_if.mem_din, 8'h00);
    check("rst_sim_halt", bus_if.sim_halt, 1'b0);
    check("rst_halt_code", bus_if.halt_code, 8'h00);
    check("rst_tx_valid", bus_if.tx_valid, 1'b0);
    check("rst_io_buf_full", bus_if.io_buffer_full, 1'b0);
    check("rst_rx_ready", bus_if.rx_ready, 1'b1);
    rst = 1'b0;
    rd("stat_after_rst", 32'h0003_0004, STAT_BASE);

    // RAM latency, read-first and aliasing
    wr(32'h0000_0000, 8'h5E);
    wr(32'h0000_0011, 8'h3C);
    wr(32'h0000_0010, 8'hA5);
    rd("ram_rd_10", 32'h0000_0010, 8'hA5);
    rd("ram_rd_11", 32'h0000_0011, 8'h3C);
    rd_q.push_back(8'hA5);
    bus_cyc(32'h0000_0010, 1'b1, 8'h77);
    check("ram_read_first", bus_if.mem_din, rd_q.pop_front());
    rd("ram_new_10", 32'h0000_0010, 8'h77);
    rd("ram_alias", 32'h8002_0010, 8'h77);
    rd("ram_idle_b0", 32'h0000_0000, 8'h5E);
    rd("io_unmapped", 32'h0003_0002, 8'h00);

    // RX single byte
    bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h5A; rx_model.push_back(8'h5A);
    cyc();
    bus_if.rx_valid = 1'b0;
    rd("stat_rx_ne", 32'h0003_0004, STAT_BASE | 8'h01);
    rd("rx_head", 32'h0003_0000, rx_model.pop_front());
    rd("rx_empty_rd", 32'h0003_0000, 8'h00);
    rd("stat_rx_empty", 32'h0003_0004, STAT_BASE);

    // RX fill to full, refused push, drain with a simultaneous push/pop
    for (int i = 0; i < 8; i++) begin
      bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'hC0 + 8'(i);
      rx_model.push_back(8'hC0 + 8'(i));
      cyc();
    end
    bus_if.rx_data = 8'hEE;
    check("rx_ready_full", bus_if.rx_ready, 1'b0);
    cyc();
    bus_if.rx_valid = 1'b0;
    for (int i = 0; i < 7; i++) rd("rx_fill_rd", 32'h0003_0000, rx_model.pop_front());
    bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h99;
    rd_q.push_back(rx_model.pop_front());
    rx_model.push_back(8'h99);
    bus_cyc(32'h0003_0000, 1'b0, 8'h00);
    bus_if.rx_valid = 1'b0;
    check("rx_push_pop", bus_if.mem_din, rd_q.pop_front());
    rd("rx_after_pp", 32'h0003_0000, rx_model.pop_front());
    rd("rx_drained", 32'h0003_0000, 8'h00);

    // Halt register
    check("halt_pre", bus_if.sim_halt, 1'b0);
    wr(32'h0003_0004, 8'h07);
    check("halt_set", bus_if.sim_halt, 1'b1);
    check("halt_code", bus_if.halt_code, 8'h07);
    wr(32'h0003_0004, 8'h09);
    check("halt_code_sticky", bus_if.halt_code, 8'h07);

    // TX fill, almost-full and overflow
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tx_model.push_back(8'(8'h11 * (i + 1)));
      wr(32'h0003_0000, 8'(8'h11 * (i + 1)));
      check("io_buf_full", bus_if.io_buffer_full, (i == 6));
    end
    check("tx_valid_held", bus_if.tx_valid, 1'b1);
    check("tx_data_head", bus_if.tx_data, tx_model[0]);
    cyc();
    check("tx_data_stable", bus_if.tx_data, tx_model[0]);
    tx_model.push_back(8'h88);
    wr(32'h0003_0000, 8'h88);
    rd("stat_tx_full", 32'h0003_0004, STAT_BASE | 8'h02);
    wr(32'h0003_0000, 8'h99);
    rd("stat_tx_ovf", 32'h0003_0004, STAT_BASE | 8'h06);

    // TX drain with pacing
    bus_if.tx_ready = 1'b1;
    last = -1;
    for (int c = 0; c < 200 && tx_model.size() > 0; c++) begin
      if (bus_if.tx_valid) begin
        check("tx_data", bus_if.tx_data, tx_model.pop_front());
        if (last >= 0) check("tx_gap", 32'(c - last), 32'(TX_GAP + 1));
        last = c;
      end
      cyc();
    end
    check("tx_drain_left", 32'(tx_model.size()), 32'd0);
    cyc();
    check("tx_valid_empty", bus_if.tx_valid, 1'b0);
    bus_if.tx_ready = 1'b0;
    rd("stat_ovf_sticky", 32'h0003_0004, STAT_BASE | 8'h04);

    // Reset mid-burst with a pending RAM read
    for (int i = 0; i < 7; i++) wr(32'h0003_0000, 8'hE0 + 8'(i));
    check("burst_buf_full", bus_if.io_buffer_full, 1'b1);
    rst = 1'b1;
    bus_if.mem_a = 32'h0000_0010;
    cyc();
    bus_if.mem_a = '0;
    check("mid_rst_tx_valid", bus_if.tx_valid, 1'b0);
    check("mid_rst_buf_full", bus_if.io_buffer_full, 1'b0);
    check("mid_rst_mem_din", bus_if.mem_din, 8'h00);
    check("mid_rst_halt", bus_if.sim_halt, 1'b0);
    check("mid_rst_halt_code", bus_if.halt_code, 8'h00);
    rst = 1'b0;
    rd("stat_post_rst", 32'h0003_0004, STAT_BASE);
    check("post_rst_tx_valid", bus_if.tx_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
